// File: rtl/pattern_scan_ctrl_if.sv
// Host-side bundle for the pattern scan controller: configuration, word handshake,
// serial bit stream, match reporting and the scan busy/done status.
interface pattern_scan_ctrl_if #(
  parameter int PAT_W  = 4,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
);
  logic              cfg_we_i;
  logic [PAT_W-1:0]  cfg_pattern_i;
  logic              start_i;
  logic              word_valid_i;
  logic [WORD_W-1:0] word_data_i;
  logic              word_last_i;
  logic              word_ready_o;
  logic              bit_out_o;
  logic              bit_valid_o;
  logic              match_o;
  logic [CNT_W-1:0]  match_count_o;
  logic              overflow_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output cfg_we_i, cfg_pattern_i, start_i, word_valid_i, word_data_i, word_last_i,
    input  word_ready_o, bit_out_o, bit_valid_o, match_o, match_count_o,
           overflow_o, busy_o, done_o
  );

  modport slave (
    input  cfg_we_i, cfg_pattern_i, start_i, word_valid_i, word_data_i, word_last_i,
    output word_ready_o, bit_out_o, bit_valid_o, match_o, match_count_o,
           overflow_o, busy_o, done_o
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scan controller: serializes requester words MSB-first and counts
// overlapping PAT_W-bit pattern matches per scan, reported with a busy/done handshake.
module pattern_scan_ctrl #(
  parameter int               PAT_W   = 4,
  parameter int               WORD_W  = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1010)
) (
  input logic                clk,
  input logic                rst_n,
  pattern_scan_ctrl_if.slave scan
);
  localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              match_q, match_d;

  logic              cur_bit;
  logic [PAT_W-1:0]  window;
  logic              hit;

  assign cur_bit = word_q[idx_q];
  assign window  = {hist_q, cur_bit};
  // A match needs a full history so the first PAT_W-1 bits of a scan never fire.
  assign hit     = (state_q == S_SHIFT) && (fill_q == FILL_MAX) && (window == pat_q);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    match_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scan.cfg_we_i) begin
          pat_d = scan.cfg_pattern_i;
        end
        if (scan.start_i) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        cnt_d   = '0;
        ovf_d   = 1'b0;
        hist_d  = '0;
        fill_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (scan.word_valid_i) begin
          word_d  = scan.word_data_i;
          last_d  = scan.word_last_i;
          idx_d   = IDX_TOP;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        hist_d = window[PAT_W-2:0];
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + 1'b1;
        end
        if (hit) begin
          match_d = 1'b1;
          if (&cnt_q) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (idx_q == '0) begin
          state_d = last_q ? S_DONE : S_WAIT;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= RST_PAT;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
    end
  end

  assign scan.word_ready_o  = (state_q == S_WAIT);
  assign scan.bit_valid_o   = (state_q == S_SHIFT);
  assign scan.bit_out_o     = (state_q == S_SHIFT) && cur_bit;
  assign scan.busy_o        = (state_q == S_ARM) || (state_q == S_WAIT) || (state_q == S_SHIFT);
  assign scan.done_o        = (state_q == S_DONE);
  assign scan.match_o       = match_q;
  assign scan.match_count_o = cnt_q;
  assign scan.overflow_o    = ovf_q;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: a wide-counter and a 2-bit-counter instance share stimulus
// and are checked every cycle against a bit-stream/window reference model.
module tb_pattern_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_scan_ctrl_if #(.PAT_W(4), .WORD_W(8), .CNT_W(8)) s1 ();
  pattern_scan_ctrl_if #(.PAT_W(4), .WORD_W(8), .CNT_W(2)) s2 ();

  assign s2.cfg_we_i      = s1.cfg_we_i;
  assign s2.cfg_pattern_i = s1.cfg_pattern_i;
  assign s2.start_i       = s1.start_i;
  assign s2.word_valid_i  = s1.word_valid_i;
  assign s2.word_data_i   = s1.word_data_i;
  assign s2.word_last_i   = s1.word_last_i;

  pattern_scan_ctrl #(.PAT_W(4), .WORD_W(8), .CNT_W(8), .RST_PAT(4'b1010)) dut1 (
    .clk(clk), .rst_n(rst_n), .scan(s1));
  pattern_scan_ctrl #(.PAT_W(4), .WORD_W(8), .CNT_W(2), .RST_PAT(4'b1010)) dut2 (
    .clk(clk), .rst_n(rst_n), .scan(s2));

  typedef struct {
    logic       cfg;
    logic       cws;
    logic [3:0] pat;
    int         n;
    logic [7:0] w0;
    logic [7:0] w1;
    int         hits;
    int         cnt8;
    int         cnt2;
    logic       ovf2;
  } vec_t;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] model_pat;
  logic [7:0] wbuf [0:7];
  logic       bits [0:63];
  int         nw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic drive_word(input int wi, input int gapmax);
    s1.word_valid_i = (wi < nw) && ($urandom_range(0, gapmax) == 0);
    s1.word_data_i  = s1.word_valid_i ? wbuf[wi] : 8'($urandom);
    s1.word_last_i  = s1.word_valid_i ? (wi == nw - 1) : 1'($urandom_range(0, 1));
  endtask

  // One complete scan of wbuf[0..nw-1]; every cycle is compared with the stream model.
  task automatic do_scan(input bit cfg, input bit cws, input logic [3:0] pat,
                         input bit noise, input int gapmax, output int hits);
    int  total, k, wi, mh;
    bit  pend, exp_done, exp_bv, finished;
    total = nw * 8; k = 0; wi = 0; mh = 0;
    pend = 0; exp_done = 0; finished = 0;
    @(negedge clk);
    chk("idle_busy", s1.busy_o, 0);
    chk("idle_done", s1.done_o, 0);
    if (cfg && !cws) begin
      s1.cfg_we_i = 1'b1; s1.cfg_pattern_i = pat; model_pat = pat;
      @(negedge clk);
      s1.cfg_we_i = 1'b0;
    end
    s1.start_i = 1'b1;
    if (cfg && cws) begin
      s1.cfg_we_i = 1'b1; s1.cfg_pattern_i = pat; model_pat = pat;
    end
    @(negedge clk);
    s1.start_i = 1'b0; s1.cfg_we_i = 1'b0;
    chk("arm_busy", s1.busy_o, 1);
    chk("arm_ready", s1.word_ready_o, 0);
    drive_word(wi, gapmax);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      chk("match", s1.match_o, pend);
      chk("match_c2", s2.match_o, pend);
      if (pend) mh++;
      pend = 0;
      chk("count", s1.match_count_o, sat(mh, 255));
      chk("count_c2", s2.match_count_o, sat(mh, 3));
      chk("ovf", s1.overflow_o, mh > 255);
      chk("ovf_c2", s2.overflow_o, mh > 3);
      chk("done", s1.done_o, exp_done);
      if (exp_done) begin
        chk("done_busy", s1.busy_o, 0);
        chk("done_ready", s1.word_ready_o, 0);
        finished = 1;
      end else begin
        exp_bv = (k < 8 * wi);
        chk("busy", s1.busy_o, 1);
        chk("bit_valid", s1.bit_valid_o, exp_bv);
        chk("word_ready", s1.word_ready_o, !exp_bv);
        if (exp_bv) begin
          bits[k] = wbuf[k / 8][7 - (k % 8)];
          chk("bit_out", s1.bit_out_o, bits[k]);
          if (k >= 3) begin
            if ({bits[k-3], bits[k-2], bits[k-1], bits[k]} == model_pat) pend = 1;
          end
          k++;
          if (k == total) exp_done = 1;
        end
        s1.start_i       = noise && exp_bv && ($urandom_range(0, 1) == 1);
        s1.cfg_we_i      = noise && exp_bv && ($urandom_range(0, 1) == 1);
        s1.cfg_pattern_i = 4'($urandom);
        drive_word(wi, gapmax);
        if (!exp_bv && s1.word_valid_i) wi++;
      end
    end
    if (!finished) chk("scan_timeout", 0, 1);
    s1.start_i = 1'b0; s1.cfg_we_i = 1'b0; s1.word_valid_i = 1'b0;
    hits = mh;
  endtask

  initial begin
    vec_t vt [6];
    int   h, nb;
    logic [3:0] rp;
    vt[0] = '{1'b0, 1'b0, 4'b1010, 1, 8'h55, 8'h00, 2, 2, 2, 1'b0};
    vt[1] = '{1'b0, 1'b0, 4'b1010, 2, 8'h05, 8'h00, 1, 1, 1, 1'b0};
    vt[2] = '{1'b1, 1'b0, 4'b1111, 1, 8'hFF, 8'h00, 5, 5, 3, 1'b1};
    vt[3] = '{1'b1, 1'b1, 4'b1010, 1, 8'h55, 8'h00, 2, 2, 2, 1'b0};
    vt[4] = '{1'b0, 1'b0, 4'b1010, 1, 8'h00, 8'h00, 0, 0, 0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 4'b0011, 2, 8'h33, 8'h33, 4, 4, 3, 1'b1};

    s1.cfg_we_i = 1'b0; s1.cfg_pattern_i = 4'b0000; s1.start_i = 1'b0;
    s1.word_valid_i = 1'b0; s1.word_data_i = 8'h00; s1.word_last_i = 1'b0;
    model_pat = 4'b1010;
    repeat (2) @(negedge clk);
    chk("rst_busy", s1.busy_o, 0);
    chk("rst_ready", s1.word_ready_o, 0);
    chk("rst_bit_valid", s1.bit_valid_o, 0);
    chk("rst_count", s1.match_count_o, 0);
    chk("rst_done", s1.done_o, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      nw = vt[i].n; wbuf[0] = vt[i].w0; wbuf[1] = vt[i].w1;
      do_scan(vt[i].cfg, vt[i].cws, vt[i].pat, 1'b0, 0, h);
      chk($sformatf("vec%0d_hits", i), h, vt[i].hits);
      chk($sformatf("vec%0d_cnt8", i), s1.match_count_o, vt[i].cnt8);
      chk($sformatf("vec%0d_cnt2", i), s2.match_count_o, vt[i].cnt2);
      chk($sformatf("vec%0d_ovf2", i), s2.overflow_o, vt[i].ovf2);
    end

    // cfg_we/start noise while shifting must not disturb the scan or the pattern.
    nw = 1; wbuf[0] = 8'h55; model_pat = 4'b1010;
    do_scan(1'b1, 1'b1, 4'b1010, 1'b1, 0, h);
    chk("noise_hits", h, 2);
    do_scan(1'b0, 1'b0, 4'b0000, 1'b0, 0, h);
    chk("noise_pat_kept", h, 2);

    // Asynchronous reset in the middle of a word.
    @(negedge clk);
    s1.cfg_we_i = 1'b1; s1.cfg_pattern_i = 4'b1111; s1.start_i = 1'b1;
    s1.word_valid_i = 1'b1; s1.word_data_i = 8'hFF; s1.word_last_i = 1'b1;
    @(negedge clk);
    s1.cfg_we_i = 1'b0; s1.start_i = 1'b0;
    nb = 0;
    for (int c = 0; c < 30 && nb < 6; c++) begin
      @(negedge clk);
      if (s1.bit_valid_o) nb++;
    end
    s1.word_valid_i = 1'b0;
    chk("rst_pre_bits", nb, 6);
    chk("rst_pre_count", s1.match_count_o, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", s1.busy_o, 0);
    chk("arst_ready", s1.word_ready_o, 0);
    chk("arst_bit_valid", s1.bit_valid_o, 0);
    chk("arst_count", s1.match_count_o, 0);
    chk("arst_count_c2", s2.match_count_o, 0);
    chk("arst_match", s1.match_o, 0);
    chk("arst_done", s1.done_o, 0);
    @(negedge clk);
    chk("arst_no_done", s1.done_o, 0);
    rst_n = 1'b1;
    model_pat = 4'b1010;
    nw = 1; wbuf[0] = 8'h55;
    do_scan(1'b0, 1'b0, 4'b0000, 1'b0, 0, h);
    chk("post_rst_hits", h, 2);

    // Randomized scans against the model.
    for (int r = 0; r < 30; r++) begin
      rp = 4'($urandom);
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        case ($urandom_range(0, 3))
          0: wbuf[w] = 8'($urandom);
          1: wbuf[w] = {rp, rp};
          2: wbuf[w] = 8'hFF;
          default: wbuf[w] = 8'h00;
        endcase
      end
      do_scan($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rp,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3), h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Scan controller for the serial pattern-detection path. Accepts parallel words from a requester over a valid/ready handshake and serializes them MSB-first onto a bit stream.
- Runs a programmable, overlapping PAT_W-bit pattern match on that stream. Counts matches per scan and reports completion with a busy/done handshake.
- Sits between a host/requester and the serial detector datapath; owns pattern configuration and scan sequencing.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
WORD_W, 8, input word width (>=PAT_W not required)
CNT_W, 8, match counter width
RST_PAT, 4'b1010, pattern value loaded at reset (PAT_W bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cfg_we  in  1  pattern write strobe, honoured only in IDLE
cfg_pattern  in  PAT_W  new pattern, first-received bit at MSB
start  in  1  begin scan; honoured only in IDLE
word_valid  in  1  requester has a word
word_data  in  WORD_W  word to serialize, MSB sent first
word_last  in  1  qualifies final word of scan
word_ready  out  1  controller accepts word this cycle
bit_out  out  1  current serial bit
bit_valid  out  1  bit_out valid (one bit per SHIFT cycle)
match  out  1  one-cycle pulse per detected pattern
match_count  out  CNT_W  matches in current/last scan, saturating
overflow  out  1  sticky, count saturated this scan
busy  out  1  high in ARM/WAIT/SHIFT
done  out  1  one-cycle pulse at scan end

Behaviour:
- Reset (rst=0, async): state IDLE; pattern=RST_PAT; all outputs 0; history, fill, shift reg, bit index cleared.
- All other updates occur on the rising edge of clk.
- IDLE: word_ready=0, busy=0.
  - cfg_we=1 loads cfg_pattern.
  - start=1 goes to ARM. If cfg_we and start are high together, the pattern is loaded and used by this scan.
- ARM (1 cycle): clears match_count, overflow, history, fill; goes to WAIT.
- WAIT: word_ready=1.
  - On word_valid&word_ready: capture word_data and word_last, bit index=WORD_W-1, go to SHIFT.
  - Without word_valid: stay in WAIT indefinitely.
- SHIFT: bit_valid=1, bit_out=captured word[index]; one bit per cycle for exactly WORD_W cycles.
  - After the final bit: go to DONE if the captured last flag=1, else to WAIT.
  - Throughput: one word per WORD_W+1 cycles.
- DONE (1 cycle): done=1, busy=0; goes to IDLE. match_count and overflow hold until the next ARM.
- Matching:
  - history = last PAT_W-1 serialized bits; fill counts bits seen, saturating at PAT_W-1.
  - On each bit_valid cycle: if fill==PAT_W-1 and {history,bit_out}==pattern, match=1 next cycle and match_count increments on the same edge.
  - Overlapping matches count. Matches span word boundaries within a scan but never across scans (ARM clears history/fill).
- Latency: match pulse and count update appear the cycle after the bit completing the pattern. A match on the last bit of a scan appears in the DONE cycle, so match_count is final whenever done=1.
- Saturation: at all-ones, further matches still pulse match, count holds, overflow=1 (sticky until ARM).
- Ignored events:
  - start while busy or in DONE.
  - cfg_we outside IDLE.
  - word_valid outside WAIT (word_ready=0).
- Reset mid-scan: immediate return to IDLE with all reset values; the partially sent word is lost and no done pulse is issued.

Test Plan:
- Pattern 1010, start, one word 8'b01010101 last=1 -> bit_out 0,1,0,1,0,1,0,1; match pulses after bits 4 and 6 (0-based); done with match_count=2, overflow=0.
- Pattern 1010, words 8'b00000101 then 8'b00000000 last=1 (word_valid held) -> word_ready gaps of 8 cycles; one cross-boundary match (bits 5..8); done with match_count=1.
- cfg_we pattern 1111 in IDLE, word 8'hFF last -> 5 matches (overlap), count=5. Repeat with CNT_W=2 -> count saturates at 3, overflow=1, match still pulses 5 times.
- Back-to-back scans with pattern 1010: scan 1 ends in bits ..101, scan 2 starts with 0 -> no cross-scan match; count restarts at 0 on ARM.
- Assert cfg_we=1 (pattern 0000) and start=1 during SHIFT -> both ignored; pattern unchanged, scan continues, single done.
- Drive rst=0 mid-SHIFT after 3 bits -> busy, word_ready, bit_valid, match_count drop to 0 asynchronously; pattern returns to 1010; no done; a new scan after release operates normally.
